// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: stage enables/flushes, load-use/branch/trap sequencing, EX forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctl #(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned TRAP_BUBBLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_d,
    input  logic [4:0]  i_rs2_d,
    input  logic [4:0]  i_rs1_e,
    input  logic [4:0]  i_rs2_e,
    input  logic [4:0]  i_rd_e,
    input  logic        i_reg_wr_e,
    input  logic [1:0]  i_result_src_e,
    input  logic        i_pc_src_e,
    input  logic [4:0]  i_rd_m,
    input  logic        i_reg_wr_m,
    input  logic [4:0]  i_rd_w,
    input  logic        i_reg_wr_w,
    input  logic        i_trap_m,
    input  logic        i_mem_busy,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic [1:0]  o_fwd_a_e,
    output logic [1:0]  o_fwd_b_e,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 32;

    localparam logic [CNT_W-1:0] LD_CNT_INIT   = CNT_W'((LOAD_BUBBLES > 1) ? (LOAD_BUBBLES - 2) : 0);
    localparam logic [CNT_W-1:0] TRAP_CNT_INIT = CNT_W'((TRAP_BUBBLES > 0) ? (TRAP_BUBBLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_TRAP     = 2'b10,
        ST_RSVD     = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              lu_c;

    // Load in EX whose destination is read by the instruction in decode.
    assign lu_c = (i_result_src_e == 2'b01) && i_reg_wr_e && (i_rd_e != '0) &&
                  ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;

        if (i_rst) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            state_d        = ST_RUN;
            cnt_d          = '0;
        end else if (i_trap_m) begin
            // Trap wins over a busy memory; the pending access is dropped with EX_MEM.
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            state_d        = ST_TRAP;
            cnt_d          = TRAP_CNT_INIT;
        end else if (i_mem_busy) begin
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
        end else if (i_pc_src_e) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            state_d       = ST_RUN;
            cnt_d         = '0;
        end else begin
            case (state_q)
                ST_TRAP: begin
                    o_if_id_flush = 1'b1;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_LD_STALL: begin
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_RUN: begin
                    if (lu_c) begin
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_d = ST_LD_STALL;
                            cnt_d   = LD_CNT_INIT;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_state = 2'(state_q);

    // MEM result is newer than WB, so it is checked first.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input logic [REG_W-1:0] rd_m, input logic wr_m,
                                           input logic [REG_W-1:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != '0) && (rd_m == rs))      return 2'b10;
        else if (wr_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
        else                                           return 2'b00;
    endfunction

    assign o_fwd_a_e = fwd_sel(i_rs1_e, i_rd_m, i_reg_wr_m, i_rd_w, i_reg_wr_w);
    assign o_fwd_b_e = fwd_sel(i_rs2_e, i_rd_m, i_reg_wr_m, i_rd_w, i_reg_wr_w);

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_q, flush_q;
    logic              flush_acc_c;

    // A branch is only taken up when no trap or memory wait pre-empts it.
    assign flush_acc_c = i_trap_m || (i_pc_src_e && !i_mem_busy);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!o_pc_en && (stall_q != '1))    stall_q <= stall_q + PERF_W'(1);
            if (flush_acc_c && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_flush_events = flush_q;
`else
    assign o_stall_cycles = '0;
    assign o_flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: two instances (LOAD_BUBBLES=3/TRAP_BUBBLES=2 and 1/1) share stimulus.
module tb_hazard_ctl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_rd_m, i_rd_w;
    logic        i_reg_wr_e, i_pc_src_e, i_reg_wr_m, i_reg_wr_w, i_trap_m, i_mem_busy;
    logic [1:0]  i_result_src_e;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_fl1, id_ex_fl1, ex_mem_fl1;
    logic [1:0]  fwd_a1, fwd_b1, state1;
    logic [31:0] stall_cnt1, flush_cnt1;

    logic [7:0]  ctl, ctl1;
    assign ctl  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl};
    assign ctl1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_fl1, id_ex_fl1, ex_mem_fl1};

    // {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, ex_mem flushes}
    localparam logic [7:0] C_RST    = 8'b00000_111;
    localparam logic [7:0] C_NORM   = 8'b11111_000;
    localparam logic [7:0] C_STALL  = 8'b00111_010;
    localparam logic [7:0] C_BRANCH = 8'b11111_110;
    localparam logic [7:0] C_TRAP   = 8'b11111_111;
    localparam logic [7:0] C_TRAPD  = 8'b11111_100;
    localparam logic [7:0] C_BUSY   = 8'b00000_000;

    int checks = 0;
    int errors = 0;

    hazard_ctl #(.LOAD_BUBBLES(3), .TRAP_BUBBLES(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d),
        .i_rs1_e(i_rs1_e), .i_rs2_e(i_rs2_e), .i_rd_e(i_rd_e), .i_reg_wr_e(i_reg_wr_e),
        .i_result_src_e(i_result_src_e), .i_pc_src_e(i_pc_src_e), .i_rd_m(i_rd_m),
        .i_reg_wr_m(i_reg_wr_m), .i_rd_w(i_rd_w), .i_reg_wr_w(i_reg_wr_w),
        .i_trap_m(i_trap_m), .i_mem_busy(i_mem_busy),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en), .o_ex_mem_en(ex_mem_en),
        .o_mem_wb_en(mem_wb_en), .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
        .o_ex_mem_flush(ex_mem_fl), .o_fwd_a_e(fwd_a), .o_fwd_b_e(fwd_b), .o_state(state),
        .o_stall_cycles(stall_cnt), .o_flush_events(flush_cnt)
    );

    hazard_ctl #(.LOAD_BUBBLES(1), .TRAP_BUBBLES(1)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d),
        .i_rs1_e(i_rs1_e), .i_rs2_e(i_rs2_e), .i_rd_e(i_rd_e), .i_reg_wr_e(i_reg_wr_e),
        .i_result_src_e(i_result_src_e), .i_pc_src_e(i_pc_src_e), .i_rd_m(i_rd_m),
        .i_reg_wr_m(i_reg_wr_m), .i_rd_w(i_rd_w), .i_reg_wr_w(i_reg_wr_w),
        .i_trap_m(i_trap_m), .i_mem_busy(i_mem_busy),
        .o_pc_en(pc_en1), .o_if_id_en(if_id_en1), .o_id_ex_en(id_ex_en1), .o_ex_mem_en(ex_mem_en1),
        .o_mem_wb_en(mem_wb_en1), .o_if_id_flush(if_id_fl1), .o_id_ex_flush(id_ex_fl1),
        .o_ex_mem_flush(ex_mem_fl1), .o_fwd_a_e(fwd_a1), .o_fwd_b_e(fwd_b1), .o_state(state1),
        .o_stall_cycles(stall_cnt1), .o_flush_events(flush_cnt1)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter expectations collapse to zero when the counters are not built.
    function automatic logic [31:0] pexp(input int unsigned n);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_load(input logic on);
        i_result_src_e = on ? 2'b01 : 2'b00;
        i_reg_wr_e     = on;
        i_rd_e         = 5'd5;
        i_rs1_d        = 5'd5;
    endtask

    initial begin
        i_rst = 1'b1;
        i_rs1_d = '0; i_rs2_d = '0; i_rs1_e = '0; i_rs2_e = '0; i_rd_e = '0;
        i_rd_m = '0; i_rd_w = '0; i_reg_wr_e = 1'b0; i_reg_wr_m = 1'b0; i_reg_wr_w = 1'b0;
        i_result_src_e = 2'b00; i_pc_src_e = 1'b0; i_trap_m = 1'b0; i_mem_busy = 1'b0;
        settle();
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl1", 32'(ctl1), 32'(C_RST));

        tick(); i_rst = 1'b0; settle();
        chk("idle_ctl", 32'(ctl), 32'(C_NORM));
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_stall", stall_cnt, 32'd0);

        // Load-use: 3 bubbles on dut, 1 on dut1.
        tick(); set_load(1'b1); settle();
        chk("lu_c1_ctl", 32'(ctl), 32'(C_STALL));
        chk("lu_c1_state", 32'(state), 32'd0);
        chk("lu1_c1_ctl", 32'(ctl1), 32'(C_STALL));
        tick(); set_load(1'b0); settle();
        chk("lu_c2_ctl", 32'(ctl), 32'(C_STALL));
        chk("lu_c2_state", 32'(state), 32'd1);
        chk("lu1_c2_ctl", 32'(ctl1), 32'(C_NORM));
        chk("lu1_c2_state", 32'(state1), 32'd0);
        tick(); settle();
        chk("lu_c3_ctl", 32'(ctl), 32'(C_STALL));
        chk("lu_c3_state", 32'(state), 32'd1);
        tick(); settle();
        chk("lu_c4_ctl", 32'(ctl), 32'(C_NORM));
        chk("lu_c4_state", 32'(state), 32'd0);
        chk("lu_stall_cnt", stall_cnt, pexp(3));
        chk("lu_stall_cnt1", stall_cnt1, pexp(1));

        // Taken branch in cycle 2 of the stall aborts it.
        tick(); set_load(1'b1); settle();
        chk("br_c1_ctl", 32'(ctl), 32'(C_STALL));
        tick(); set_load(1'b0); i_pc_src_e = 1'b1; settle();
        chk("br_c2_ctl", 32'(ctl), 32'(C_BRANCH));
        chk("br_c2_state", 32'(state), 32'd1);
        chk("br1_c2_ctl", 32'(ctl1), 32'(C_BRANCH));
        tick(); i_pc_src_e = 1'b0; settle();
        chk("br_c3_ctl", 32'(ctl), 32'(C_NORM));
        chk("br_c3_state", 32'(state), 32'd0);
        chk("br_flush_cnt", flush_cnt, pexp(1));

        // Trap coinciding with memory wait.
        tick(); i_trap_m = 1'b1; i_mem_busy = 1'b1; settle();
        chk("tr_c1_ctl", 32'(ctl), 32'(C_TRAP));
        tick(); i_trap_m = 1'b0; i_mem_busy = 1'b0; settle();
        chk("tr_c2_ctl", 32'(ctl), 32'(C_TRAPD));
        chk("tr_c2_state", 32'(state), 32'd2);
        chk("tr1_c2_state", 32'(state1), 32'd2);
        tick(); settle();
        chk("tr_c3_ctl", 32'(ctl), 32'(C_TRAPD));
        chk("tr1_c3_ctl", 32'(ctl1), 32'(C_NORM));
        tick(); settle();
        chk("tr_c4_ctl", 32'(ctl), 32'(C_NORM));
        chk("tr_c4_state", 32'(state), 32'd0);
        chk("tr_flush_cnt", flush_cnt, pexp(2));

        // Second trap during TRAP restarts the countdown.
        tick(); i_trap_m = 1'b1; settle();
        tick(); i_trap_m = 1'b0; settle();
        chk("rt_c2_state", 32'(state), 32'd2);
        tick(); i_trap_m = 1'b1; settle();
        chk("rt_c3_ctl", 32'(ctl), 32'(C_TRAP));
        tick(); i_trap_m = 1'b0; settle();
        chk("rt_c4_ctl", 32'(ctl), 32'(C_TRAPD));
        tick(); settle();
        chk("rt_c5_ctl", 32'(ctl), 32'(C_TRAPD));
        tick(); settle();
        chk("rt_c6_state", 32'(state), 32'd0);
        chk("rt_flush_cnt1", flush_cnt1, pexp(4));

        // Memory wait for 4 cycles inside LD_STALL freezes the bubble count.
        tick(); set_load(1'b1); settle();
        chk("mb_c1_ctl", 32'(ctl), 32'(C_STALL));
        tick(); set_load(1'b0); i_mem_busy = 1'b1; settle();
        for (int i = 0; i < 4; i++) begin
            chk("mb_busy_ctl", 32'(ctl), 32'(C_BUSY));
            chk("mb_busy_state", 32'(state), 32'd1);
            chk("mb1_busy_ctl", 32'(ctl1), 32'(C_BUSY));
            if (i < 3) begin
                tick(); settle();
            end
        end
        tick(); i_mem_busy = 1'b0; settle();
        chk("mb_r1_ctl", 32'(ctl), 32'(C_STALL));
        chk("mb_r1_state", 32'(state), 32'd1);
        tick(); settle();
        chk("mb_r2_ctl", 32'(ctl), 32'(C_STALL));
        chk("mb_r2_state", 32'(state), 32'd1);
        tick(); settle();
        chk("mb_r3_ctl", 32'(ctl), 32'(C_NORM));
        chk("mb_r3_state", 32'(state), 32'd0);
        chk("mb_stall_cnt", stall_cnt, pexp(11));
        chk("mb_stall_cnt1", stall_cnt1, pexp(7));

        // Reset mid-stall leaves no residual bubbles.
        tick(); set_load(1'b1); settle();
        tick(); set_load(1'b0); i_rst = 1'b1; settle();
        chk("rs_ctl", 32'(ctl), 32'(C_RST));
        tick(); i_rst = 1'b0; settle();
        chk("rs_after_ctl", 32'(ctl), 32'(C_NORM));
        chk("rs_after_state", 32'(state), 32'd0);
        chk("rs_stall_cnt", stall_cnt, 32'd0);
        chk("rs_flush_cnt", flush_cnt, 32'd0);

        // Forwarding selects.
        i_rd_m = 5'd7; i_rd_w = 5'd7; i_reg_wr_m = 1'b1; i_reg_wr_w = 1'b1;
        i_rs1_e = 5'd7; i_rs2_e = 5'd0; settle();
        chk("fw_a_mem", 32'(fwd_a), 32'd2);
        chk("fw_b_x0", 32'(fwd_b), 32'd0);
        i_rd_m = 5'd0; settle();
        chk("fw_a_wb", 32'(fwd_a), 32'd1);
        i_rd_m = 5'd7; i_reg_wr_m = 1'b0; i_rs2_e = 5'd7; settle();
        chk("fw_a_nowr_m", 32'(fwd_a), 32'd1);
        chk("fw_b_wb", 32'(fwd_b), 32'd1);
        i_reg_wr_w = 1'b0; settle();
        chk("fw_a_none", 32'(fwd_a), 32'd0);
        i_rd_w = 5'd0; i_rs1_e = 5'd0; i_reg_wr_w = 1'b1; settle();
        chk("fw_a_wb_x0", 32'(fwd_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard controller for the five-stage core. It generates the clock-enable and flush strobes for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers, and the EX-stage forwarding selects. It sequences load-use bubbles, taken-branch/jump squashes, data-memory wait freezes and trap drains. It sits beside the datapath and drives the `i_clk_en` / `i_id_ex_flush` pins of the stage registers.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard (1..7).
- TRAP_BUBBLES, 2: cycles IF_ID stays flushed after a trap or mret redirect (1..7).
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_rs1_d, i_rs2_d  in  5 each  decode-stage source registers.
- i_rs1_e, i_rs2_e, i_rd_e  in  5 each  execute-stage registers.
- i_reg_wr_e  in  1  EX instruction writes rd.
- i_result_src_e  in  2  EX result source; 2'b01 = load.
- i_pc_src_e  in  1  taken branch or jump resolved in EX.
- i_rd_m, i_reg_wr_m  in  5, 1  MEM-stage destination and write flag.
- i_rd_w, i_reg_wr_w  in  5, 1  WB-stage destination and write flag.
- i_trap_m  in  1  ecall, mret or exception committing in MEM.
- i_mem_busy  in  1  data memory not ready this cycle.
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage-register enables.
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush  out  1 each  stage-register flushes.
- o_fwd_a_e, o_fwd_b_e  out  2 each  ALU operand select: 00 register file, 10 from MEM, 01 from WB.
- o_state  out  2  current FSM state.
- o_stall_cycles, o_flush_events  out  32 each  performance counters (see Configuration).

## Operation
- Load-use hazard (`lu`) is asserted when all hold: i_result_src_e==2'b01, i_reg_wr_e, i_rd_e!=0, and i_rd_e equals i_rs1_d or i_rs2_d.
- FSM states:
  - RUN=00.
  - LD_STALL=01.
  - TRAP=10.
  - 11 is unused and returns to RUN.
- 3-bit down-counter `cnt`.
- Default outputs: all enables 1, all flushes 0.
- Priority per cycle, highest first:
  1. i_rst: all enables 0; IF_ID/ID_EX/EX_MEM flush 1; next state RUN; cnt=0.
  2. i_trap_m: o_ex_mem_flush, o_id_ex_flush and o_if_id_flush = 1; o_pc_en=1 (PC loads the vector); next state TRAP; cnt=TRAP_BUBBLES-1. This overrides i_mem_busy, and the pending access is cancelled.
  3. i_mem_busy: all enables 0, no flushes. State and cnt hold.
  4. i_pc_src_e: o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1; next state RUN. This aborts any LD_STALL.
  5. State-specific behaviour:
     - TRAP: o_if_id_flush=1. If cnt==0, go to RUN; else cnt-1.
     - LD_STALL: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. If cnt==0, go to RUN; else cnt-1.
     - RUN with lu: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1. If LOAD_BUBBLES>1, go to LD_STALL with cnt=LOAD_BUBBLES-2; else stay in RUN.
- Forwarding is purely combinational and independent of state:
  - MEM has priority over WB.
  - Source is MEM when i_reg_wr_m && i_rd_m!=0 && i_rd_m==i_rs1_e (likewise for rs2).
  - Source is WB under the same test using the _w signals.
  - Otherwise the select is 00.
- Every flush output is asserted together with its stage's enable, or with the enable don't-care; stage registers give flush precedence.

## Timing
- All enables, flushes and selects are combinational from inputs and registered state, with zero-cycle latency.
- A load-use costs exactly LOAD_BUBBLES cycles of o_pc_en=0.
- A trap gives 1 + TRAP_BUBBLES cycles with o_if_id_flush=1. The trap cycle itself is the +1.
- A new i_trap_m during TRAP restarts cnt.
- i_mem_busy during LD_STALL or TRAP freezes the countdown; no cycles are lost or gained.
- Reset mid-stall or mid-trap returns to RUN on the next edge, with no residual bubbles.
- o_state after reset is 00.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_stall_cycles increments on every cycle with o_pc_en=0 and not i_rst.
  - o_flush_events increments on each cycle where i_trap_m or i_pc_src_e is accepted.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- HAZARD_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Load-use: load x5 in EX, rs1_d=5, LOAD_BUBBLES=1 -> one cycle with o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1; o_state stays 00.
- LOAD_BUBBLES=3 with the same stimulus -> 3 consecutive stall cycles, o_state=01 for cycles 2-3, then 00.
- Taken branch arriving in cycle 2 of that stall -> o_if_id_flush=1 and o_id_ex_flush=1, o_pc_en=1, o_state returns to 00 immediately.
- i_trap_m asserted together with i_mem_busy, TRAP_BUBBLES=2 -> all three flushes asserted, then o_if_id_flush held 2 more cycles; o_flush_events +1 with the macro defined.
- i_mem_busy held 4 cycles during LD_STALL -> all enables 0 for 4 cycles, cnt frozen, remaining bubbles intact afterward.
- Forwarding: rd_m=rd_w=7 with both write flags set, rs1_e=7 -> o_fwd_a_e=10; rd_m=0 instead -> 01; rs2_e=0 -> o_fwd_b_e=00.
